// File: rtl/uart_tx_serializer_if.sv
// Handshake/data bundle between the core's memory-mapped UART logic and the TX serializer.
// The core drives the master side; the serializer implements the slave side.
interface uart_tx_serializer_if #(
   parameter int UART_Nbit = 8
);
   logic                 Tx_start;
   logic [UART_Nbit-1:0] DataTx_in;
   logic                 SerialDataOut;
   logic                 Tx_busy;
   logic                 Tx_done;

   modport master (
      output Tx_start,
      output DataTx_in,
      input  SerialDataOut,
      input  Tx_busy,
      input  Tx_done
   );

   modport slave (
      input  Tx_start,
      input  DataTx_in,
      output SerialDataOut,
      output Tx_busy,
      output Tx_done
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches a word on Tx_start and shifts it out LSB-first as 8N1, with registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit (8E1).
module uart_tx_serializer #(
   parameter int UART_Nbit = 8,
   parameter int baudrate  = 9600,
   parameter int clk_freq  = 50000000
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_serializer_if.slave tx
);
   localparam int CLKS_PER_BIT = clk_freq / baudrate;
   localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = (UART_Nbit > 1) ? $clog2(UART_Nbit) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_Nbit - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      , S_PARITY = 3'd4
`endif
   } state_t;

   state_t               state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [UART_Nbit-1:0] shift_q, shift_d;
   logic                 line_q, line_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif
   logic                 bit_end;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         line_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         line_q   <= line_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Line value is computed for the state being entered, so it changes on the same edge as the state.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      line_d   = line_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      bit_end  = (baud_q == BAUD_LAST);

      if (state_q != S_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            line_d = 1'b1;
            busy_d = 1'b0;
            if (tx.Tx_start) begin
               shift_d  = tx.DataTx_in;
`ifdef UART_TX_PARITY_EN
               parity_d = ^tx.DataTx_in;
`endif
               state_d  = S_START;
               line_d   = 1'b0;
               busy_d   = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
               line_d  = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  line_d  = parity_q;
`else
                  state_d = S_STOP;
                  line_d  = 1'b1;
`endif
               end else begin
                  idx_d  = idx_q + 1'b1;
                  line_d = shift_d[0];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               line_d  = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               line_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            line_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign tx.SerialDataOut = line_q;
   assign tx.Tx_busy       = busy_q;
   assign tx.Tx_done       = done_q;

endmodule
